ysyx_22040175_mem_resp: RTL and testbench
=========================================

YSYX_22040175_MEM_RESP -- requirements
Module: ysyx_22040175_mem_resp

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 64'h0000_0000_8000_0000, meaning the byte address of word 0.
REQ-002 The block SHALL have parameter DEPTH, default 1024, meaning the number of 64-bit words (power of two).
REQ-003 The block SHALL have parameter LATENCY, default 2, legal 0..15, meaning the wait cycles inserted before each response.
REQ-004 The block SHALL have a single clock, port clk, and a synchronous active-high reset, port rst.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_addr  in  64  byte address; bits [2:0] ignored.
- req_wen  in  1  1 = store, 0 = load/fetch.
- req_wdata  in  64  store data.
- req_wmask  in  8  byte-enable; bit i covers wdata[8i+7:8i].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  64  load data; 0 for stores and errors.
- rsp_err  out  1  address out of range.

Function
REQ-006 The block SHALL be the responder side of the core's fetch/load-store request interface, with one transaction outstanding at a time.
REQ-007 The block SHALL implement the states IDLE, WAIT and RESP.
REQ-008 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid&&req_ready is 1 at a clk edge.
REQ-009 On acceptance the block SHALL latch addr, wen, wdata and wmask, and SHALL load the wait counter with LATENCY.
REQ-010 From IDLE on acceptance, the block SHALL go to WAIT if LATENCY>0, else directly to RESP.
REQ-011 In WAIT the counter SHALL decrement each cycle, and the block SHALL enter RESP on the edge at which the counter reads 1.
REQ-012 rsp_valid SHALL rise exactly LATENCY+1 cycles after the acceptance edge.
REQ-013 Range check: an address is in range iff BASE_ADDR <= addr < BASE_ADDR+DEPTH*8, using unsigned 64-bit compare with no wrap-around.
REQ-014 Word index SHALL be (addr-BASE_ADDR)>>3, truncated to log2(DEPTH) bits.
REQ-015 Store commit SHALL happen on the edge entering RESP:
- for each byte i with wmask[i]=1, mem byte i <= wdata byte i; other bytes unchanged;
- wmask=0 writes nothing but still responds.
REQ-016 Load data SHALL be captured into rsp_rdata on the same edge from the pre-edge array contents, so a store in a prior transaction is always visible.
REQ-017 An out-of-range request SHALL give rsp_err=1 and rsp_rdata=0, with no array write.
REQ-018 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1.
REQ-019 When rsp_valid&&rsp_ready is 1, the block SHALL return to IDLE and drop rsp_valid; req_ready is 1 the next cycle, so there is no same-cycle re-accept.
REQ-020 rsp_ready asserted outside RESP SHALL be ignored.
REQ-021 A req_valid deassertion or a payload change outside IDLE SHALL be ignored.

Reset
REQ-022 When rst=1 at an edge: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 from the first cycle after reset.
REQ-023 A reset asserted in WAIT SHALL abort the transaction with no store commit; a reset in RESP SHALL discard the pending response.
REQ-024 Array contents SHALL NOT be reset.

Structure
REQ-025 A shared package SHALL hold the state enum (IDLE/WAIT/RESP), the BASE_ADDR/DEPTH/LATENCY defaults and the 64-bit data width constant.
REQ-026 The byte-merge SHALL be one combinational sub-module, ysyx_22040175_wmask_merge (old word, wdata, wmask -> new word).

Verification
REQ-027 Store then load, LATENCY=2: store 0x8000_0010 wdata=0x1122334455667788 wmask=0xFF -> rsp_valid 3 cycles after accept, rdata 0. Load 0x8000_0013 -> rdata 0x1122334455667788, err 0.
REQ-028 Partial mask: word holds 0xFFFF_FFFF_FFFF_FFFF; store wdata 0, wmask=0x0F -> load returns 0xFFFF_FFFF_0000_0000.
REQ-029 Range boundary, DEPTH=1024: load 0x8000_1FF8 -> err 0. Load 0x8000_2000 -> err 1, rdata 0. Store 0x7FFF_FFF8 -> err 1, array unchanged.
REQ-030 Backpressure and latency: hold rsp_ready=0 for 5 cycles -> response fields stable and req_ready=0 throughout. With LATENCY=0 -> rsp_valid on the cycle after accept.
REQ-031 Reset mid-operation: accept store 0xDEAD to 0x8000_0000 and assert rst during WAIT -> no response; a later load of 0x8000_0000 returns the prior value. After reset rsp_valid=0 and req_ready=1.

Source files
------------

// File: rtl/ysyx_22040175_mem_resp_pkg.sv
// Shared types and defaults for the simulated memory responder.
package ysyx_22040175_mem_resp_pkg;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W = 4;

  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h0000_0000_8000_0000;
  localparam int DEFAULT_DEPTH = 1024;
  localparam int DEFAULT_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;
endpackage

// File: rtl/ysyx_22040175_wmask_merge.sv
// Byte-granular merge of store data into an existing word.
module ysyx_22040175_wmask_merge
  import ysyx_22040175_mem_resp_pkg::*;
(
  input  logic [DATA_W-1:0] old_word,
  input  logic [DATA_W-1:0] wdata,
  input  logic [MASK_W-1:0] wmask,
  output logic [DATA_W-1:0] new_word
);
  generate
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_byte
      assign new_word[8*gi +: 8] = wmask[gi] ? wdata[8*gi +: 8] : old_word[8*gi +: 8];
    end
  endgenerate
endmodule

// File: rtl/ysyx_22040175_mem_resp.sv
// Single-outstanding memory responder: accepts one request, waits LATENCY
// cycles, commits/reads the word array and holds the response until taken.
module ysyx_22040175_mem_resp
  import ysyx_22040175_mem_resp_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          DEPTH     = DEFAULT_DEPTH,
  parameter int          LATENCY   = DEFAULT_LATENCY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [63:0]       req_addr,
  input  logic              req_wen,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [MASK_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + (65'(DEPTH) << 3);
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LATENCY);

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [63:0]       addr_reg;
  logic              wen_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [MASK_W-1:0] wmask_reg;
  logic [DATA_W-1:0] rdata_reg;
  logic              err_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              enter_resp;
  logic              in_idle;
  logic [63:0]       eff_addr;
  logic              eff_wen;
  logic [DATA_W-1:0] eff_wdata;
  logic [MASK_W-1:0] eff_wmask;
  logic [63:0]       addr_aligned;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged_word;

  assign in_idle   = (state_reg == IDLE);
  assign req_ready = in_idle;
  assign rsp_valid = (state_reg == RESP);
  assign rsp_rdata = rdata_reg;
  assign rsp_err   = err_reg;
  assign accept    = req_valid && req_ready;

  // With zero latency the commit edge is the acceptance edge, so the live
  // request fields are used in IDLE and the latched copy everywhere else.
  assign eff_addr  = in_idle ? req_addr  : addr_reg;
  assign eff_wen   = in_idle ? req_wen   : wen_reg;
  assign eff_wdata = in_idle ? req_wdata : wdata_reg;
  assign eff_wmask = in_idle ? req_wmask : wmask_reg;

  assign addr_aligned = eff_addr & ~64'h7;
  assign in_range = ({1'b0, addr_aligned} >= {1'b0, BASE_ADDR}) &&
                    ({1'b0, addr_aligned} < LIMIT);
  assign idx      = IDX_W'((addr_aligned - BASE_ADDR) >> 3);
  assign old_word = mem[idx];

  ysyx_22040175_wmask_merge u_merge (
    .old_word (old_word),
    .wdata    (eff_wdata),
    .wmask    (eff_wmask),
    .new_word (merged_word)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    enter_resp = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next = LAT_CNT;
          if (LAT_CNT == '0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg <= 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (enter_resp) begin
        err_reg   <= !in_range;
        rdata_reg <= (!eff_wen && in_range) ? old_word : '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_reg  <= req_addr;
      wen_reg   <= req_wen;
      wdata_reg <= req_wdata;
      wmask_reg <= req_wmask;
    end
  end

  // Array is never reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && eff_wen && in_range) mem[idx] <= merged_word;
  end
endmodule

// File: tb/tb_ysyx_22040175_mem_resp.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0.
module tb_ysyx_22040175_mem_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid;
  logic        rsp_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [63:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [63:0] b_rsp_rdata;

  logic        rr, rv, er;
  logic [63:0] rd;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign rr = sel ? b_req_ready : a_req_ready;
  assign rv = sel ? b_rsp_valid : a_rsp_valid;
  assign er = sel ? b_rsp_err   : a_rsp_err;
  assign rd = sel ? b_rsp_rdata : a_rsp_rdata;

  ysyx_22040175_mem_resp #(.LATENCY(2)) u_a (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid && !sel),
    .req_ready (a_req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (a_rsp_valid),
    .rsp_ready (rsp_ready && !sel),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  ysyx_22040175_mem_resp #(.LATENCY(0)) u_b (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid && sel),
    .req_ready (b_req_ready),
    .req_addr  (req_addr),
    .req_wen   (req_wen),
    .req_wdata (req_wdata),
    .req_wmask (req_wmask),
    .rsp_valid (b_rsp_valid),
    .rsp_ready (rsp_ready && sel),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request/response; hold = cycles to keep rsp_ready low after rsp_valid.
  task automatic txn(input string tag, input logic [63:0] addr, input logic wen,
                     input logic [63:0] wdata, input logic [7:0] wmask, input int hold,
                     input logic [63:0] exp_rdata, input logic exp_err);
    int k;
    logic [63:0] rd0;
    logic er0;
    @(negedge clk);
    check({tag, " ready_before"}, 64'(rr), 64'd1);
    req_addr = addr; req_wen = wen; req_wdata = wdata; req_wmask = wmask;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = ~addr; req_wen = ~wen; req_wdata = ~wdata; req_wmask = ~wmask;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rv !== 1'b1 && k < 40);
    check({tag, " latency"}, 64'(k), sel ? 64'd1 : 64'd3);
    check({tag, " ready_in_resp"}, 64'(rr), 64'd0);
    rd0 = rd;
    er0 = er;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, 64'(rv), 64'd1);
      check({tag, " hold_rdata"}, rd, rd0);
      check({tag, " hold_err"}, 64'(er), 64'(er0));
      check({tag, " hold_ready"}, 64'(rr), 64'd0);
    end
    check({tag, " rdata"}, rd, exp_rdata);
    check({tag, " err"}, 64'(er), 64'(exp_err));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, " valid_after"}, 64'(rv), 64'd0);
    check({tag, " ready_after"}, 64'(rr), 64'd1);
    $display("txn %s sel=%0d addr=%h wen=%0d wmask=%h rdata=%h err=%0d lat=%0d",
             tag, sel, addr, wen, wmask, rd0, er0, k);
  endtask

  initial begin
    sel = 1'b0; rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_addr = '0; req_wen = 1'b0; req_wdata = '0; req_wmask = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset a valid", 64'(rv), 64'd0);
    check("reset a rdata", rd, 64'd0);
    check("reset a err", 64'(er), 64'd0);
    check("reset a ready", 64'(rr), 64'd1);
    sel = 1'b1;
    check("reset b valid", 64'(rv), 64'd0);
    check("reset b ready", 64'(rr), 64'd1);
    sel = 1'b0;

    txn("st_full",  64'h8000_0010, 1'b1, 64'h1122334455667788, 8'hFF, 0, 64'h0, 1'b0);
    txn("ld_full",  64'h8000_0013, 1'b0, 64'h0, 8'h00, 0, 64'h1122334455667788, 1'b0);
    txn("st_ones",  64'h8000_0020, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 64'h0, 1'b0);
    txn("st_low",   64'h8000_0020, 1'b1, 64'h0, 8'h0F, 0, 64'h0, 1'b0);
    txn("ld_part",  64'h8000_0020, 1'b0, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_0000_0000, 1'b0);
    txn("st_nomask", 64'h8000_0020, 1'b1, 64'h0, 8'h00, 0, 64'h0, 1'b0);
    txn("ld_nomask", 64'h8000_0020, 1'b0, 64'h0, 8'h00, 0, 64'hFFFF_FFFF_0000_0000, 1'b0);
    txn("st_top",   64'h8000_1FF8, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 8'hFF, 0, 64'h0, 1'b0);
    txn("ld_top",   64'h8000_1FF8, 1'b0, 64'h0, 8'h00, 0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    txn("ld_past",  64'h8000_2000, 1'b0, 64'h0, 8'h00, 0, 64'h0, 1'b1);
    txn("st_below", 64'h7FFF_FFF8, 1'b1, 64'h1234, 8'hFF, 0, 64'h0, 1'b1);
    txn("ld_top2",  64'h8000_1FF8, 1'b0, 64'h0, 8'h00, 0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    txn("st_base0", 64'h8000_0000, 1'b1, 64'h0BAD_F00D, 8'hFF, 0, 64'h0, 1'b0);
    txn("st_past",  64'h8000_2000, 1'b1, 64'h5555, 8'hFF, 0, 64'h0, 1'b1);
    txn("ld_base0", 64'h8000_0000, 1'b0, 64'h0, 8'h00, 0, 64'h0BAD_F00D, 1'b0);
    txn("ld_bp",    64'h8000_0010, 1'b0, 64'h0, 8'h00, 5, 64'h1122334455667788, 1'b0);

    // Reset while the store is still waiting: no response and no commit.
    @(negedge clk);
    req_addr = 64'h8000_0000; req_wen = 1'b1; req_wdata = 64'hDEAD; req_wmask = 8'hFF;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid wait valid", 64'(rv), 64'd0);
    check("rstmid wait ready", 64'(rr), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid after valid", 64'(rv), 64'd0);
    check("rstmid after ready", 64'(rr), 64'd1);
    repeat (4) begin
      @(negedge clk);
      check("rstmid quiet valid", 64'(rv), 64'd0);
    end
    $display("txn rstmid addr=%h aborted", 64'h8000_0000);
    txn("ld_rstmid", 64'h8000_0000, 1'b0, 64'h0, 8'h00, 0, 64'h0BAD_F00D, 1'b0);

    sel = 1'b1;
    txn("l0_st_full", 64'h8000_0008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, 64'h0, 1'b0);
    txn("l0_st_part", 64'h8000_0008, 1'b1, 64'hCAFE, 8'h03, 0, 64'h0, 1'b0);
    txn("l0_ld",      64'h8000_000F, 1'b0, 64'h0, 8'h00, 2, 64'h0123_4567_89AB_CAFE, 1'b0);
    txn("l0_ld_err",  64'h8000_2000, 1'b0, 64'h0, 8'h00, 0, 64'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
